// File: rtl/seg_scan_if.sv
// Multiplexed 7-segment bus in, reconstructed BCD frame out.
// Master drives the display lines; slave is the scan decoder.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] digits_out;
  logic [DIGITS-1:0]   blank_out;
  logic                frame_valid;
  logic                frame_err;

  modport master (
    output seg_in, an_in,
    input  digits_out, blank_out,
    input  frame_valid, frame_err
  );

  modport slave (
    input  seg_in, an_in,
    output digits_out, blank_out,
    output frame_valid, frame_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a scanned 7-segment bus.
// Optional SEG_SCAN_ERR_CNT_EN adds a saturating invalid-pattern counter.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
`ifdef SEG_SCAN_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = DIGITS + 7;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]          w_new;
  logic [SW-1:0]          r_samp;
  logic [CW-1:0]          r_cnt;
  logic                   w_eq;
  logic                   w_commit;
  logic [DIGITS-1:0]      w_an;
  logic [6:0]             w_seg;
  logic                   w_onehot;
  logic [IW-1:0]          w_idx;
  logic [3:0]             w_val;
  logic                   w_blk;
  logic                   w_inv;
  logic                   w_wr;
  logic [DIGITS-1:0]      w_set;
  logic                   w_full;
  logic [DIGITS-1:0]      r_seen;
  logic                   r_ferr;
  logic [DIGITS-1:0][3:0] r_shd;
  logic [DIGITS-1:0]      r_shb;
  logic [DIGITS-1:0][3:0] r_dig;
  logic [DIGITS-1:0]      r_blk;
  logic                   r_fv;
  logic                   r_fe;

  assign w_new    = {bus.an_in, bus.seg_in};
  assign w_eq     = (w_new == r_samp);
  // Fires once, on the increment that reaches STABLE_CYCLES
  assign w_commit = w_eq && (r_cnt == CLAST);
  assign w_an     = r_samp[SW-1:7];
  assign w_seg    = r_samp[6:0];
  assign w_onehot = (w_an != '0) &&
                    ((w_an & (w_an - DIGITS'(1))) == '0);
  assign w_wr     = w_commit && w_onehot;
  assign w_set    = w_wr ? (DIGITS'(1) << w_idx) : '0;
  assign w_full   = &r_seen;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (w_an[i]) w_idx = IW'(i);
  end

  always_comb begin
    w_val = 4'hF;
    w_inv = 1'b1;
    w_blk = 1'b0;
    case (w_seg)
      7'h3F: begin w_val = 4'd0; w_inv = 1'b0; end
      7'h06: begin w_val = 4'd1; w_inv = 1'b0; end
      7'h5B: begin w_val = 4'd2; w_inv = 1'b0; end
      7'h4F: begin w_val = 4'd3; w_inv = 1'b0; end
      7'h66: begin w_val = 4'd4; w_inv = 1'b0; end
      7'h6D: begin w_val = 4'd5; w_inv = 1'b0; end
      7'h7D: begin w_val = 4'd6; w_inv = 1'b0; end
      7'h07: begin w_val = 4'd7; w_inv = 1'b0; end
      7'h7F: begin w_val = 4'd8; w_inv = 1'b0; end
      7'h67: begin w_val = 4'd9; w_inv = 1'b0; end
      7'h00: begin
        w_val = 4'd0;
        w_inv = 1'b0;
        w_blk = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= '0;
      r_cnt  <= '0;
    end else begin
      r_samp <= w_new;
      if (!w_eq)
        r_cnt <= '0;
      else if (r_cnt != CMAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd <= '0;
      r_shb <= '0;
    end else if (w_wr) begin
      r_shd[w_idx] <= w_val;
      r_shb[w_idx] <= w_blk;
    end
  end

  // A commit on the publishing edge starts the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
      r_ferr <= 1'b0;
      r_dig  <= '0;
      r_blk  <= '1;
      r_fv   <= 1'b0;
      r_fe   <= 1'b0;
    end else if (w_full) begin
      r_seen <= w_set;
      r_ferr <= w_wr & w_inv;
      r_dig  <= r_shd;
      r_blk  <= r_shb;
      r_fv   <= 1'b1;
      r_fe   <= r_ferr;
    end else begin
      r_seen <= r_seen | w_set;
      r_ferr <= r_ferr | (w_wr & w_inv);
      r_fv   <= 1'b0;
      r_fe   <= 1'b0;
    end
  end

`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0] r_ecnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ecnt <= '0;
    else if (w_wr && w_inv && r_ecnt != 8'hFF)
      r_ecnt <= r_ecnt + 8'd1;
  end

  assign err_cnt = r_ecnt;
`endif

  assign bus.digits_out  = r_dig;
  assign bus.blank_out   = r_blk;
  assign bus.frame_valid = r_fv;
  assign bus.frame_err   = r_fe;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed plan plus
// random scan traffic checked against a frame-level model.
module tb_seg_scan_decoder;
  localparam int D = 4;
  localparam int S = 4;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic        e;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(D)) bus ();

`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0] err_cnt;
  seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .err_cnt(err_cnt)
  );
`else
  seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
`endif

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

  int n_chk = 0;
  int n_err = 0;
  int frames = 0;
  frame_t q[$];
  logic [15:0] last_d;
  logic [3:0]  last_b;
  logic        last_e;

  // Reference model state
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_dig [D];
  logic [3:0]  m_blk;
  logic [3:0]  m_seen;
  logic        m_ferr;
  int          m_ecnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    m_prev = '0;
    m_run  = 1;
    m_blk  = '0;
    m_seen = '0;
    m_ferr = 1'b0;
    m_ecnt = 0;
    for (int i = 0; i < D; i++) m_dig[i] = 4'h0;
  endtask

  task automatic m_commit(input logic [3:0] an, input logic [6:0] seg);
    int idx;
    logic [3:0] val;
    logic inv, blk;
    frame_t f;
    if ($countones(an) != 1) return;
    idx = 0;
    for (int i = 0; i < D; i++) if (an[i]) idx = i;
    val = 4'hF; inv = 1'b1; blk = 1'b0;
    if (seg == 7'h00) begin
      val = 4'h0; inv = 1'b0; blk = 1'b1;
    end else begin
      for (int k = 0; k < 10; k++)
        if (pat[k] == seg) begin val = 4'(k); inv = 1'b0; end
    end
    m_dig[idx]  = val;
    m_blk[idx]  = blk;
    m_seen[idx] = 1'b1;
    m_ferr      = m_ferr | inv;
    if (inv && m_ecnt < 255) m_ecnt++;
    if (m_seen == 4'hF) begin
      f.d = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      f.b = m_blk;
      f.e = m_ferr;
      q.push_back(f);
      m_seen = '0;
      m_ferr = 1'b0;
    end
  endtask

  // A value commits once it has been present at S+1 consecutive edges
  task automatic m_step(input logic [3:0] an, input logic [6:0] seg);
    logic [10:0] v;
    v = {an, seg};
    if (v == m_prev) m_run++;
    else begin m_prev = v; m_run = 1; end
    if (m_run == S + 1) m_commit(an, seg);
  endtask

  // Called at a negedge; returns at a negedge
  task automatic drive(input logic [3:0] an, input logic [6:0] seg,
                       input int n);
    for (int c = 0; c < n; c++) begin
      bus.an_in  = an;
      bus.seg_in = seg;
      m_step(an, seg);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    chk("queue_empty_at_reset", 32'(q.size()), 32'd0);
    q.delete();
    rst_n = 1'b0;
    bus.an_in  = '0;
    bus.seg_in = '0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst_digits", 32'(bus.digits_out), 32'h0);
    chk("rst_blank", 32'(bus.blank_out), 32'hF);
    chk("rst_valid", 32'(bus.frame_valid), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
`ifdef SEG_SCAN_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err && !bus.frame_valid)
        chk("ferr_without_valid", 32'h1, 32'h0);
      if (bus.frame_valid) begin
        frame_t e;
        frames++;
        last_d = bus.digits_out;
        last_b = bus.blank_out;
        last_e = bus.frame_err;
        if (q.size() == 0) begin
          chk("unexpected_frame", 32'(bus.digits_out), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("sb_digits", 32'(bus.digits_out), 32'(e.d));
          chk("sb_blank", 32'(bus.blank_out), 32'(e.b));
          chk("sb_ferr", 32'(bus.frame_err), 32'(e.e));
        end
      end
    end
  end

  task automatic frame4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
    drive(4'b0001, s0, 8);
    drive(4'b0010, s1, 8);
    drive(4'b0100, s2, 8);
    drive(4'b1000, s3, 8);
  endtask

  initial begin
    int f0;
    logic [3:0] an;
    logic [6:0] seg;
    bus.an_in  = '0;
    bus.seg_in = '0;
    @(negedge clk);
    do_reset();

    f0 = frames;
    frame4(pat[3], pat[1], pat[4], pat[2]);
    chk("t1_count", 32'(frames - f0), 32'd1);
    chk("t1_digits", 32'(last_d), 32'h2413);
    chk("t1_blank", 32'(last_b), 32'h0);
    chk("t1_ferr", 32'(last_e), 32'h0);

    f0 = frames;
    drive(4'b0001, pat[2], 3);
    frame4(pat[1], pat[5], pat[6], pat[7]);
    chk("t2_count", 32'(frames - f0), 32'd1);
    chk("t2_glitch", 32'(last_d), 32'h7651);

    frame4(pat[8], pat[9], 7'h70, pat[0]);
    chk("t3_digits", 32'(last_d), 32'h0F98);
    chk("t3_ferr", 32'(last_e), 32'h1);
`ifdef SEG_SCAN_ERR_CNT_EN
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
`endif

    f0 = frames;
    drive(4'b0011, 7'h70, 8);
    chk("t4_no_frame", 32'(frames - f0), 32'd0);
    frame4(pat[1], pat[2], pat[3], pat[4]);
    chk("t4_count", 32'(frames - f0), 32'd1);
    chk("t4_digits", 32'(last_d), 32'h4321);
`ifdef SEG_SCAN_ERR_CNT_EN
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif

    frame4(pat[5], 7'h00, pat[6], pat[9]);
    chk("t5_digits", 32'(last_d), 32'h9605);
    chk("t5_blank", 32'(last_b), 32'b0010);

    drive(4'b0001, pat[7], 8);
    drive(4'b0010, pat[8], 8);
    do_reset();
    f0 = frames;
    frame4(pat[2], pat[0], pat[1], pat[3]);
    drive(4'b0000, 7'h00, 6);
    chk("t6_count", 32'(frames - f0), 32'd1);
    chk("t6_digits", 32'(last_d), 32'h3102);

    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 9) < 8) an = 4'(1 << $urandom_range(0, 3));
      else an = 4'($urandom);
      case ($urandom_range(0, 19))
        0, 1, 2:       seg = 7'h00;
        3, 4, 5, 6, 7: seg = 7'($urandom);
        default:       seg = pat[$urandom_range(0, 9)];
      endcase
      drive(an, seg, $urandom_range(1, 8));
    end
    drive(4'b0000, 7'h00, 10);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
`ifdef SEG_SCAN_ERR_CNT_EN
    chk("final_err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
